// File: rtl/hdmi_packet_pkg.sv
// Shared packet-type codes, BCH generator and drain FSM state for the
// HDMI data-island receive path.
package hdmi_packet_pkg;

    localparam logic [7:0] PKT_NULL         = 8'h00;
    localparam logic [7:0] PKT_ACR          = 8'h01;
    localparam logic [7:0] PKT_AUDIO_SAMPLE = 8'h02;
    localparam logic [7:0] PKT_AVI          = 8'h82;
    localparam logic [7:0] PKT_AUDIO_INFO   = 8'h84;

    // G(x) = 1 + x^6 + x^7 + x^8 in right-shifting (LSB-first) form
    localparam logic [7:0] BCH_POLY = 8'h83;

    typedef enum logic {
        DRAIN_IDLE = 1'b0,
        DRAIN_EMIT = 1'b1
    } drain_state_t;

    function automatic logic [7:0] bch_step(input logic [7:0] parity, input logic bit_in);
        return (parity >> 1) ^ (((parity[0] ^ bit_in) == 1'b1) ? BCH_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/bch_serial_check.sv
// Serial BCH parity accumulator, LSB first, one or two bits per pixel.
// With clear high the accumulation restarts from zero on the same cycle.
module bch_serial_check
    import hdmi_packet_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                      clk_pixel,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic                      enable,
    input  logic [BITS_PER_CYCLE-1:0] data,
    output logic [7:0]                parity
);

    logic [7:0] parity_reg;
    logic [7:0] parity_next;

    // data[0] is the earlier (even) bit of the pair
    always_comb begin
        parity_next = clear ? 8'h00 : parity_reg;
        for (int b = 0; b < BITS_PER_CYCLE; b++) begin
            parity_next = bch_step(parity_next, data[b]);
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            parity_reg <= 8'h00;
        end else if (enable) begin
            parity_reg <= parity_next;
        end
    end

    assign parity = parity_reg;

endmodule

// File: rtl/packet_decoder.sv
// Data-island packet receiver: deserializes TERC4 nibbles, checks BCH parity,
// decodes ACR N/CTS and drains Audio Sample subpackets one stereo sample per cycle.
module packet_decoder
    import hdmi_packet_pkg::*;
#(
    parameter int AUDIO_BIT_WIDTH = 16
) (
    input  logic                            clk_pixel,
    input  logic                            reset_n,
    input  logic                            island_valid,
    input  logic [3:0]                      ch0,
    input  logic [3:0]                      ch1,
    input  logic [3:0]                      ch2,
    output logic                            packet_valid,
    output logic [23:0]                     header,
    output logic [3:0][55:0]                sub,
    output logic                            header_err,
    output logic [3:0]                      sub_err,
    output logic [19:0]                     n,
    output logic [19:0]                     cts,
    output logic                            acr_update,
    output logic [1:0][AUDIO_BIT_WIDTH-1:0] audio_sample_word,
    output logic                            audio_sample_valid
);

    logic [4:0]   pix_reg;
    logic [30:0]  header_sr_reg;
    logic [61:0]  sub_sr_reg [4];
    logic [31:0]  header_full;
    logic [63:0]  sub_full [4];
    logic [7:0]   header_parity;
    logic [7:0]   sub_parity [4];
    logic         header_err_next;
    logic [3:0]   sub_err_next;
    logic         last_pixel;
    logic         lfsr_clear;
    logic         is_acr;
    logic         audio_start;
    logic [3:0]   audio_mask;
    drain_state_t drain_state_reg;
    logic [3:0]   drain_mask_reg;
    logic [3:0]   drain_mask_next;
    logic [1:0]   drain_idx;
    logic         unused_ch0_bits;

    assign unused_ch0_bits = ^{ch0[3], ch0[1:0]};

    assign last_pixel  = island_valid && (pix_reg == 5'd31);
    assign lfsr_clear  = (pix_reg == 5'd0);

    // The shift registers hold bits 0..30 (62 for subpackets); the live pixel completes the word
    assign header_full     = {ch0[2], header_sr_reg};
    assign header_err_next = (header_full[31:24] != header_parity);

    bch_serial_check #(
        .BITS_PER_CYCLE(1)
    ) u_header_bch (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .clear     (lfsr_clear),
        .enable    (island_valid && (pix_reg < 5'd24)),
        .data      (ch0[2]),
        .parity    (header_parity)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sub
            assign sub_full[gi]     = {ch2[gi], ch1[gi], sub_sr_reg[gi]};
            assign sub_err_next[gi] = (sub_full[gi][63:56] != sub_parity[gi]);

            bch_serial_check #(
                .BITS_PER_CYCLE(2)
            ) u_sub_bch (
                .clk_pixel (clk_pixel),
                .reset_n   (reset_n),
                .clear     (lfsr_clear),
                .enable    (island_valid && (pix_reg < 5'd28)),
                .data      ({ch2[gi], ch1[gi]}),
                .parity    (sub_parity[gi])
            );
        end
    endgenerate

    assign is_acr      = last_pixel && (header_full[7:0] == PKT_ACR) &&
                         !header_err_next && !sub_err_next[0];
    assign audio_start = last_pixel && (header_full[7:0] == PKT_AUDIO_SAMPLE) && !header_err_next;
    assign audio_mask  = header_full[11:8] & ~sub_err_next;

    // Lowest pending subpacket goes next; errored/absent ones never enter the mask
    always_comb begin
        drain_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (drain_mask_reg[i]) begin
                drain_idx = 2'(i);
            end
        end
        drain_mask_next = drain_mask_reg & ~(4'b0001 << drain_idx);
    end

    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            pix_reg            <= 5'd0;
            header_sr_reg      <= '0;
            for (int k = 0; k < 4; k++) begin
                sub_sr_reg[k] <= '0;
            end
            packet_valid       <= 1'b0;
            header             <= '0;
            sub                <= '0;
            header_err         <= 1'b0;
            sub_err            <= '0;
            n                  <= '0;
            cts                <= '0;
            acr_update         <= 1'b0;
            audio_sample_word  <= '0;
            audio_sample_valid <= 1'b0;
            drain_state_reg    <= DRAIN_IDLE;
            drain_mask_reg     <= '0;
        end else begin
            packet_valid       <= last_pixel;
            acr_update         <= is_acr;
            audio_sample_valid <= 1'b0;

            if (island_valid) begin
                pix_reg       <= pix_reg + 5'd1;
                header_sr_reg <= header_full[31:1];
                for (int k = 0; k < 4; k++) begin
                    sub_sr_reg[k] <= sub_full[k][63:2];
                end
            end else begin
                pix_reg <= 5'd0;
            end

            if (last_pixel) begin
                header     <= header_full[23:0];
                header_err <= header_err_next;
                sub_err    <= sub_err_next;
                for (int k = 0; k < 4; k++) begin
                    sub[k] <= sub_full[k][55:0];
                end
            end

            if (is_acr) begin
                cts <= {sub_full[0][11:8], sub_full[0][23:16], sub_full[0][31:24]};
                n   <= {sub_full[0][35:32], sub_full[0][47:40], sub_full[0][55:48]};
            end

            case (drain_state_reg)
                DRAIN_IDLE: begin
                    if (audio_start && (audio_mask != 4'd0)) begin
                        drain_mask_reg  <= audio_mask;
                        drain_state_reg <= DRAIN_EMIT;
                    end
                end
                DRAIN_EMIT: begin
                    audio_sample_valid   <= 1'b1;
                    audio_sample_word[0] <= sub[drain_idx][AUDIO_BIT_WIDTH-1:0];
                    audio_sample_word[1] <= sub[drain_idx][24 +: AUDIO_BIT_WIDTH];
                    drain_mask_reg       <= drain_mask_next;
                    if (drain_mask_next == 4'd0) begin
                        drain_state_reg <= DRAIN_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_packet_decoder.sv
// Scoreboard bench for packet_decoder: a transmitter model encodes packets, queues
// the expected presentation, ACR values and audio samples; a monitor checks them.
module tb_packet_decoder;

    localparam int AW = 16;

    logic                clk          = 1'b0;
    logic                reset_n      = 1'b0;
    logic                island_valid = 1'b0;
    logic [3:0]          ch0          = 4'h0;
    logic [3:0]          ch1          = 4'h0;
    logic [3:0]          ch2          = 4'h0;
    logic                packet_valid;
    logic [23:0]         header;
    logic [3:0][55:0]    sub;
    logic                header_err;
    logic [3:0]          sub_err;
    logic [19:0]         n;
    logic [19:0]         cts;
    logic                acr_update;
    logic [1:0][AW-1:0]  audio_sample_word;
    logic                audio_sample_valid;

    typedef struct {
        logic [23:0]      header;
        logic [3:0][55:0] sub;
        logic             herr;
        logic [3:0]       serr;
        logic             acr;
        logic [19:0]      n;
        logic [19:0]      cts;
        int               pv_cyc;
    } pkt_exp_t;

    typedef struct {
        logic [AW-1:0] left;
        logic [AW-1:0] right;
        int            cyc;
    } aud_exp_t;

    pkt_exp_t    pkt_q[$];
    aud_exp_t    aud_q[$];
    int          cyc      = 0;
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [19:0] mdl_n    = 20'd0;
    logic [19:0] mdl_cts  = 20'd0;

    packet_decoder #(
        .AUDIO_BIT_WIDTH(AW)
    ) dut (
        .clk_pixel          (clk),
        .reset_n            (reset_n),
        .island_valid       (island_valid),
        .ch0                (ch0),
        .ch1                (ch1),
        .ch2                (ch2),
        .packet_valid       (packet_valid),
        .header             (header),
        .sub                (sub),
        .header_err         (header_err),
        .sub_err            (sub_err),
        .n                  (n),
        .cts                (cts),
        .acr_update         (acr_update),
        .audio_sample_word  (audio_sample_word),
        .audio_sample_valid (audio_sample_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // BCH parity as the transmitter computes it: divide by G(x), bits fed LSB first
    function automatic logic [7:0] ecc_of(input logic [55:0] d, input int nbits);
        logic [7:0] e;
        e = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            e = (e >> 1) ^ (((e[0] ^ d[i]) == 1'b1) ? 8'h83 : 8'h00);
        end
        return e;
    endfunction

    function automatic logic [55:0] acr_sub(input logic [19:0] nv, input logic [19:0] cv);
        return {nv[7:0], nv[15:8], {4'h0, nv[19:16]}, cv[7:0], cv[15:8], {4'h0, cv[19:16]}, 8'h00};
    endfunction

    function automatic logic [55:0] aud_sub(input logic [AW-1:0] l, input logic [AW-1:0] r);
        logic [55:0] s;
        s = '0;
        s[AW-1:0]     = l;
        s[24 +: AW]   = r;
        return s;
    endfunction

    task automatic idle_cycle();
        island_valid = 1'b0;
        ch0 = 4'($urandom());
        ch1 = 4'($urandom());
        ch2 = 4'($urandom());
        @(posedge clk); #1;
    endtask

    task automatic drive_pixel(input logic hbit, input logic [3:0] ev, input logic [3:0] od);
        logic [3:0] r;
        r = 4'($urandom());
        island_valid = 1'b1;
        ch0 = {r[3], hbit, r[1:0]};
        ch1 = ev;
        ch2 = od;
        @(posedge clk); #1;
    endtask

    // abort_at < 32 drops island_valid before that pixel and expects nothing
    task automatic send_packet(input logic [23:0] hb, input logic [3:0][55:0] sb,
                               input logic [31:0] hflip, input logic [3:0][63:0] sflip,
                               input int abort_at);
        logic [31:0]      hp;
        logic [3:0][63:0] sp;
        logic [3:0]       ev;
        logic [3:0]       od;
        pkt_exp_t         e;
        aud_exp_t         a;
        int               e0;
        int               j;
        hp = {ecc_of({32'd0, hb}, 24), hb} ^ hflip;
        for (int k = 0; k < 4; k++) sp[k] = {ecc_of(sb[k], 56), sb[k]} ^ sflip[k];
        e0 = cyc + 1;
        if (abort_at >= 32) begin
            e.header = hp[23:0];
            e.herr   = (ecc_of({32'd0, hp[23:0]}, 24) != hp[31:24]);
            for (int k = 0; k < 4; k++) begin
                e.sub[k]  = sp[k][55:0];
                e.serr[k] = (ecc_of(sp[k][55:0], 56) != sp[k][63:56]);
            end
            e.acr    = (hp[7:0] == 8'h01) && !e.herr && !e.serr[0];
            e.cts    = {sp[0][11:8], sp[0][23:16], sp[0][31:24]};
            e.n      = {sp[0][35:32], sp[0][47:40], sp[0][55:48]};
            e.pv_cyc = e0 + 31;
            pkt_q.push_back(e);
            if ((hp[7:0] == 8'h02) && !e.herr) begin
                j = 0;
                for (int i = 0; i < 4; i++) begin
                    if (hp[8+i] && !e.serr[i]) begin
                        j++;
                        a.left  = sp[i][AW-1:0];
                        a.right = sp[i][24 +: AW];
                        a.cyc   = e0 + 31 + j;
                        aud_q.push_back(a);
                    end
                end
            end
        end
        for (int p = 0; p < 32; p++) begin
            if (p == abort_at) begin
                idle_cycle();
                return;
            end
            for (int k = 0; k < 4; k++) begin
                ev[k] = sp[k][2*p];
                od[k] = sp[k][2*p+1];
            end
            drive_pixel(hp[p], ev, od);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".packet_valid"}, packet_valid, 1'b0);
        chk({tag, ".header"}, header, 24'd0);
        for (int k = 0; k < 4; k++) chk({tag, ".sub"}, sub[k], 56'd0);
        chk({tag, ".header_err"}, header_err, 1'b0);
        chk({tag, ".sub_err"}, sub_err, 4'd0);
        chk({tag, ".n"}, n, 20'd0);
        chk({tag, ".cts"}, cts, 20'd0);
        chk({tag, ".acr_update"}, acr_update, 1'b0);
        chk({tag, ".audio_word"}, audio_sample_word, '0);
        chk({tag, ".audio_valid"}, audio_sample_valid, 1'b0);
    endtask

    always @(negedge clk) begin
        pkt_exp_t e;
        aud_exp_t a;
        if (packet_valid === 1'b1) begin
            if (pkt_q.size() == 0) begin
                chk("unexpected_packet", packet_valid, 1'b0);
            end else begin
                e = pkt_q.pop_front();
                $display("packet cyc=%0d hb=%06h herr=%0b serr=%04b acr=%0b n=%0d cts=%0d",
                         cyc, header, header_err, sub_err, acr_update, n, cts);
                chk("packet_cycle", 64'(cyc), 64'(e.pv_cyc));
                chk("header", header, e.header);
                for (int k = 0; k < 4; k++) chk("sub", sub[k], e.sub[k]);
                chk("header_err", header_err, e.herr);
                chk("sub_err", sub_err, e.serr);
                chk("acr_update", acr_update, e.acr);
                if (e.acr) begin
                    mdl_n   = e.n;
                    mdl_cts = e.cts;
                end
                chk("n", n, mdl_n);
                chk("cts", cts, mdl_cts);
            end
        end else if (acr_update === 1'b1) begin
            chk("acr_without_packet", acr_update, 1'b0);
        end
        if (audio_sample_valid === 1'b1) begin
            if (aud_q.size() == 0) begin
                chk("unexpected_sample", audio_sample_valid, 1'b0);
            end else begin
                a = aud_q.pop_front();
                $display("sample cyc=%0d left=%0h right=%0h", cyc, audio_sample_word[0], audio_sample_word[1]);
                chk("sample_left", audio_sample_word[0], a.left);
                chk("sample_right", audio_sample_word[1], a.right);
                chk("sample_cycle", 64'(cyc), 64'(a.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [23:0]      hb;
        logic [3:0][55:0] sb;
        logic [31:0]      hf;
        logic [3:0][63:0] sf;
        logic [19:0]      rn;
        logic [19:0]      rc;
        int               kind;
        int               ab;
        int               idx;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;

        // Null packet
        send_packet(24'h000000, '0, '0, '0, 32);
        repeat (2) idle_cycle();

        // ACR N=6144 CTS=25200
        for (int k = 0; k < 4; k++) sb[k] = acr_sub(20'd6144, 20'd25200);
        send_packet(24'h000001, sb, '0, '0, 32);
        repeat (2) idle_cycle();

        // Full 16-bit audio packet, all four subpackets present
        for (int i = 0; i < 4; i++)
            sb[i] = aud_sub(AW'(16'h1111 * (2*i + 1)), AW'(16'h1111 * (2*i + 2)));
        send_packet({8'h00, 8'h0F, 8'h02}, sb, '0, '0, 32);
        repeat (3) idle_cycle();

        // Header parity error: no audio, and no ACR on an ACR packet
        send_packet({8'h00, 8'h0F, 8'h02}, sb, 32'h0000_0020, '0, 32);
        repeat (2) idle_cycle();
        for (int k = 0; k < 4; k++) sb[k] = acr_sub(20'd1234, 20'd5678);
        send_packet(24'h000001, sb, 32'h0000_0020, '0, 32);
        repeat (2) idle_cycle();

        // Sub2 bit 40 flipped with present=0111: only samples 0 and 1
        for (int i = 0; i < 4; i++)
            sb[i] = aud_sub(AW'(16'h1111 * (2*i + 1)), AW'(16'h1111 * (2*i + 2)));
        sf = '0;
        sf[2][40] = 1'b1;
        send_packet({8'h00, 8'h07, 8'h02}, sb, '0, sf, 32);
        repeat (3) idle_cycle();

        // Abort at pixel 17, then a good ACR packet
        send_packet({8'h00, 8'h0F, 8'h02}, sb, '0, '0, 17);
        for (int k = 0; k < 4; k++) sb[k] = acr_sub(20'd4096, 20'd27000);
        send_packet(24'h000001, sb, '0, '0, 32);
        repeat (2) idle_cycle();

        // Back-to-back packets with island_valid held for 64 cycles
        for (int i = 0; i < 4; i++) sb[i] = aud_sub(AW'($urandom()), AW'($urandom()));
        send_packet({8'h00, 8'h0B, 8'h02}, sb, '0, '0, 32);
        for (int i = 0; i < 4; i++) sb[i] = aud_sub(AW'($urandom()), AW'($urandom()));
        send_packet({8'h00, 8'h0F, 8'h02}, sb, '0, '0, 32);
        repeat (6) idle_cycle();

        // Reset on the second drain cycle
        for (int i = 0; i < 4; i++)
            sb[i] = aud_sub(AW'(16'h1111 * (2*i + 1)), AW'(16'h1111 * (2*i + 2)));
        send_packet({8'h00, 8'h0F, 8'h02}, sb, '0, '0, 32);
        idle_cycle();
        reset_n = 1'b0;
        idle_cycle();
        pkt_q.delete();
        aud_q.delete();
        mdl_n   = 20'd0;
        mdl_cts = 20'd0;
        @(negedge clk); #1;
        check_all_zero("drain_reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (6) idle_cycle();

        // Randomized packets: mixed types, parity flips, aborts and gaps
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 4);
            hb = 24'($urandom());
            for (int k = 0; k < 4; k++) sb[k] = {24'($urandom()), 32'($urandom())};
            case (kind)
                0: begin
                    hb = 24'h000000;
                    sb = '0;
                end
                1: begin
                    hb = 24'h000001;
                    rn = 20'($urandom());
                    rc = 20'($urandom());
                    for (int k = 0; k < 4; k++) sb[k] = acr_sub(rn, rc);
                end
                2: hb[7:0] = 8'h02;
                3: hb[7:0] = 8'h82;
                default: ;
            endcase
            hf = '0;
            if ($urandom_range(0, 3) == 0) begin
                idx = $urandom_range(0, 31);
                hf[idx] = 1'b1;
            end
            sf = '0;
            if ($urandom_range(0, 3) == 0) begin
                idx = $urandom_range(0, 63);
                sf[$urandom_range(0, 3)][idx] = 1'b1;
            end
            ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 31) : 32;
            send_packet(hb, sb, hf, sf, ab);
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        repeat (10) idle_cycle();
        chk("packets_outstanding", 64'(pkt_q.size()), 64'd0);
        chk("samples_outstanding", 64'(aud_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
